// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Parity support is selected by the UART_TX_PARITY_EN macro in the top level.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Total serial bit periods in one frame: start + data + optional parity + stop.
   function automatic int unsigned frame_bits(input int unsigned data_bits,
                                              input int unsigned stop_bits,
                                              input bit          parity);
      return 1 + data_bits + int'(parity) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data_o is valid whenever empty_o is low.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_ok, rd_ok;

   // A full FIFO refuses writes even when a read frees a slot in the same cycle.
   assign wr_ok     = wr_en_i & ~full_o;
   assign rd_ok     = rd_en_i & ~empty_o;
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a word FIFO; frames go out back-to-back while data is queued.
// Optional parity bit after the data bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                          Clk,
   input  logic                          reset,
   input  logic                          T_EN,
   input  logic [DATA_BITS-1:0]          Data,
   input  logic                          Data_Valid,
   output logic                          Data_Ready,
   output logic                          Serial,
   output logic                          Transmit_Done,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

`ifdef UART_TX_PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
`else
   localparam bit HAS_PARITY = 1'b0;
`endif
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(frame_bits(DATA_BITS, STOP_BITS, HAS_PARITY));

   if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD > 1) begin : g_bad_param
      $error("uart_tx_fifo: illegal parameter value");
   end

   uart_state_e          state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 serial_q, serial_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 baud_wrap, start_c;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   logic [DATA_BITS-1:0] fifo_rd_data;
   logic                 fifo_full, fifo_empty;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (Clk),
      .rst_i     (reset),
      .wr_en_i   (Data_Valid),
      .wr_data_i (Data),
      .rd_en_i   (start_c),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (Fifo_Count)
   );

   assign Data_Ready    = ~fifo_full;
   assign Serial        = serial_q;
   assign Transmit_Done = done_q;
   assign Busy          = busy_q;

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         serial_q <= IDLE_LEVEL;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         serial_q <= serial_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      serial_d = serial_q;
      done_d   = 1'b0;
      start_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
      if (state_q != IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;

      case (state_q)
         IDLE: start_c = !fifo_empty && T_EN;
         START: begin
            if (baud_wrap) begin
               state_d  = DATA;
               serial_d = shreg_q[0];
               shreg_d  = shreg_q >> 1;
               bit_d    = '0;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d  = PARITY;
                  serial_d = par_q;
`else
                  state_d  = STOP;
                  serial_d = IDLE_LEVEL;
`endif
               end else begin
                  serial_d = shreg_q[0];
                  shreg_d  = shreg_q >> 1;
                  bit_d    = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_wrap) begin
               state_d  = STOP;
               serial_d = IDLE_LEVEL;
               bit_d    = '0;
            end
         end
`endif
         STOP: begin
            // Done is registered, so it is raised one cycle ahead of the final stop cycle.
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
               done_d = (baud_q == BAUD_W'(CLKS_PER_BIT - 2));
               if (baud_wrap) begin
                  if (!fifo_empty && T_EN) begin
                     start_c = 1'b1;
                  end else begin
                     state_d  = IDLE;
                     serial_d = IDLE_LEVEL;
                  end
               end
            end else if (baud_wrap) begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame launch, shared by IDLE and the zero-gap STOP -> START path.
      if (start_c) begin
         state_d  = START;
         serial_d = START_LEVEL;
         shreg_d  = fifo_rd_data;
         baud_d   = '0;
         bit_d    = '0;
`ifdef UART_TX_PARITY_EN
         par_d    = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
      end
      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at default parameters.
// Expected frames are hand-computed; parity variants apply when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FBITS = 11;
   // {stop, parity, data LSB-first, start}
   localparam logic [FBITS-1:0] EXP_3E = 11'h67C;
   localparam logic [FBITS-1:0] EXP_3F = 11'h47E;
   localparam logic [FBITS-1:0] EXP_40 = 11'h680;
   localparam logic [FBITS-1:0] EXP_10 = 11'h620;
`else
   localparam int FBITS = 10;
   localparam logic [FBITS-1:0] EXP_3E = 10'h27C;
   localparam logic [FBITS-1:0] EXP_3F = 10'h27E;
   localparam logic [FBITS-1:0] EXP_40 = 10'h280;
   localparam logic [FBITS-1:0] EXP_10 = 10'h220;
`endif
   localparam int FRAME = FBITS * CPB;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       T_EN = 1'b0;
   logic [7:0] Data = '0;
   logic       Data_Valid = 1'b0;
   logic       Data_Ready;
   logic       Serial;
   logic       Transmit_Done;
   logic       Busy;
   logic [3:0] Fifo_Count;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_fifo dut (
      .Clk           (Clk),
      .reset         (reset),
      .T_EN          (T_EN),
      .Data          (Data),
      .Data_Valid    (Data_Valid),
      .Data_Ready    (Data_Ready),
      .Serial        (Serial),
      .Transmit_Done (Transmit_Done),
      .Busy          (Busy),
      .Fifo_Count    (Fifo_Count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; T_EN = 1'b0; Data_Valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] w);
      Data = w; Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
   endtask

   // Records one frame starting in its first cycle; ends in its last cycle.
   task automatic capture_frame(output logic [FBITS-1:0] bits, output logic steady,
                                output int n_done, output int last_done);
      logic first;
      int   b, ph;
      bits = '0; steady = 1'b1; n_done = 0; last_done = 0; first = 1'b0;
      for (int c = 1; c <= FRAME; c++) begin
         b  = (c - 1) / CPB;
         ph = (c - 1) % CPB;
         if (ph == 0) first = Serial;
         else if (Serial !== first) steady = 1'b0;
         if (ph == CPB / 2) bits[b] = Serial;
         if (Transmit_Done === 1'b1) begin n_done++; last_done = c; end
         if (c < FRAME) tick();
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (Serial !== 1'b1) begin n_err++; $display("FAIL rst_serial: got %b want 1", Serial); end
      n_cmp++; if (Transmit_Done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", Transmit_Done); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", Busy); end
      n_cmp++; if (Fifo_Count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", Fifo_Count); end
      n_cmp++; if (Data_Ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", Data_Ready); end
   endtask

   task automatic test_single();
      logic [FBITS-1:0] bits; logic steady; int nd, ld;
      apply_reset();
      T_EN = 1'b1;
      push(8'h3E);
      n_cmp++; if (Fifo_Count !== 4'd1 || Serial !== 1'b1) begin n_err++; $display("FAIL single_queued: count %0d serial %b want 1 1", Fifo_Count, Serial); end
      tick();
      n_cmp++; if (Serial !== 1'b0 || Busy !== 1'b1) begin n_err++; $display("FAIL single_start: serial %b busy %b want 0 1", Serial, Busy); end
      capture_frame(bits, steady, nd, ld);
      n_cmp++; if (bits !== EXP_3E) begin n_err++; $display("FAIL single_bits: got %h want %h", bits, EXP_3E); end
      n_cmp++; if (steady !== 1'b1) begin n_err++; $display("FAIL single_steady: got %b want 1", steady); end
      n_cmp++; if (nd !== 1 || ld !== FRAME) begin n_err++; $display("FAIL single_done: pulses %0d at %0d want 1 at %0d", nd, ld, FRAME); end
      tick();
      n_cmp++; if (Serial !== 1'b1 || Busy !== 1'b0 || Transmit_Done !== 1'b0) begin n_err++; $display("FAIL single_end: serial %b busy %b done %b want 1 0 0", Serial, Busy, Transmit_Done); end
   endtask

   task automatic test_back_to_back();
      logic [FBITS-1:0] bits; logic steady; int nd, ld;
      logic [FBITS-1:0] exp_f [3];
      logic [3:0]       exp_c [3];
      exp_f[0] = EXP_3E; exp_f[1] = EXP_3F; exp_f[2] = EXP_40;
      exp_c[0] = 4'd2;   exp_c[1] = 4'd1;   exp_c[2] = 4'd0;
      apply_reset();
      push(8'h3E); push(8'h3F); push(8'h40);
      n_cmp++; if (Fifo_Count !== 4'd3 || Serial !== 1'b1 || Busy !== 1'b0) begin n_err++; $display("FAIL b2b_queued: count %0d serial %b busy %b want 3 1 0", Fifo_Count, Serial, Busy); end
      T_EN = 1'b1;
      for (int f = 0; f < 3; f++) begin
         tick();
         n_cmp++; if (Serial !== 1'b0 || Fifo_Count !== exp_c[f]) begin n_err++; $display("FAIL b2b_start%0d: serial %b count %0d want 0 %0d", f, Serial, Fifo_Count, exp_c[f]); end
         capture_frame(bits, steady, nd, ld);
         n_cmp++; if (bits !== exp_f[f] || steady !== 1'b1) begin n_err++; $display("FAIL b2b_bits%0d: got %h steady %b want %h 1", f, bits, steady, exp_f[f]); end
         n_cmp++; if (nd !== 1 || ld !== FRAME) begin n_err++; $display("FAIL b2b_done%0d: pulses %0d at %0d want 1 at %0d", f, nd, ld, FRAME); end
      end
      tick();
      n_cmp++; if (Serial !== 1'b1 || Busy !== 1'b0) begin n_err++; $display("FAIL b2b_end: serial %b busy %b want 1 0", Serial, Busy); end
   endtask

   task automatic test_fill();
      logic [FBITS-1:0] bits; logic steady; int nd, ld; int acc;
      apply_reset();
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         Data = 8'h10 + 8'(i); Data_Valid = 1'b1;
         if (Data_Ready === 1'b1) acc++;
         tick();
      end
      Data_Valid = 1'b0;
      n_cmp++; if (acc !== 8) begin n_err++; $display("FAIL fill_accepts: got %0d want 8", acc); end
      n_cmp++; if (Fifo_Count !== 4'd8 || Data_Ready !== 1'b0) begin n_err++; $display("FAIL fill_full: count %0d ready %b want 8 0", Fifo_Count, Data_Ready); end
      n_cmp++; if (Serial !== 1'b1 || Busy !== 1'b0) begin n_err++; $display("FAIL fill_idle: serial %b busy %b want 1 0", Serial, Busy); end
      T_EN = 1'b1;
      tick();
      n_cmp++; if (Serial !== 1'b0 || Fifo_Count !== 4'd7 || Data_Ready !== 1'b1) begin n_err++; $display("FAIL fill_pop: serial %b count %0d ready %b want 0 7 1", Serial, Fifo_Count, Data_Ready); end
      capture_frame(bits, steady, nd, ld);
      n_cmp++; if (bits !== EXP_10 || nd !== 1) begin n_err++; $display("FAIL fill_frame: got %h pulses %0d want %h 1", bits, nd, EXP_10); end
   endtask

   task automatic test_reset_mid_frame();
      logic quiet;
      apply_reset();
      push(8'h3E); push(8'h3F); push(8'h40); push(8'h41);
      T_EN = 1'b1;
      tick();
      for (int i = 0; i < CPB + 3 * CPB + 5; i++) tick();
      n_cmp++; if (Busy !== 1'b1 || Fifo_Count !== 4'd3) begin n_err++; $display("FAIL midrst_pre: busy %b count %0d want 1 3", Busy, Fifo_Count); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (Serial !== 1'b1 || Fifo_Count !== 4'd0 || Busy !== 1'b0 || Data_Ready !== 1'b1) begin n_err++; $display("FAIL midrst_post: serial %b count %0d busy %b ready %b want 1 0 0 1", Serial, Fifo_Count, Busy, Data_Ready); end
      quiet = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (Serial !== 1'b1 || Transmit_Done !== 1'b0 || Busy !== 1'b0) quiet = 1'b0;
         tick();
      end
      n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL midrst_quiet: got %b want 1", quiet); end
   endtask

   task automatic test_ten_drop();
      logic [FBITS-1:0] bits; logic steady; int nd, ld; logic held;
      apply_reset();
      push(8'h3E); push(8'h3F); push(8'h40);
      T_EN = 1'b1;
      tick();
      T_EN = 1'b0;
      n_cmp++; if (Serial !== 1'b0 || Fifo_Count !== 4'd2) begin n_err++; $display("FAIL tdrop_start: serial %b count %0d want 0 2", Serial, Fifo_Count); end
      capture_frame(bits, steady, nd, ld);
      n_cmp++; if (bits !== EXP_3E || nd !== 1 || ld !== FRAME) begin n_err++; $display("FAIL tdrop_frame: got %h pulses %0d at %0d want %h 1 at %0d", bits, nd, ld, EXP_3E, FRAME); end
      held = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (Serial !== 1'b1 || Busy !== 1'b0 || Fifo_Count !== 4'd2) held = 1'b0;
      end
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL tdrop_hold: got %b want 1", held); end
      T_EN = 1'b1;
      tick();
      n_cmp++; if (Serial !== 1'b0 || Fifo_Count !== 4'd1) begin n_err++; $display("FAIL tdrop_resume: serial %b count %0d want 0 1", Serial, Fifo_Count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_reset_mid_frame();
      test_ten_drop();
      apply_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
